// File: rtl/picorv32_mem_model.sv
// -----------------------------------------------------------------------------
// picorv32_mem_model
// Single-port memory slave for the PicoRV32 native memory interface, used in
// simulation between the core and the test-program storage.
// Features:
//   - separate read and write wait states
//   - byte-strobe writes
//   - out-of-range detection
//   - tohost end-of-test mailbox
//   - per-type access counters
// Ports:
//   clk, resetn      clock (rising edge), asynchronous active-low reset
//   mem_valid        request valid
//   mem_instr        request is an instruction fetch
//   mem_addr         byte address; bits [1:0] ignored
//   mem_wdata        write data
//   mem_wstrb        byte write enables; 4'b0000 means read
//   mem_ready        one-cycle response strobe
//   mem_rdata        read data, valid with mem_ready and held until the next read
//   tohost_valid     one-cycle pulse on a tohost write
//   tohost_data      last value written to tohost
//   oor_err          sticky out-of-range flag
//   fetch_cnt        completed instruction fetches
//   load_cnt         completed data reads
//   store_cnt        completed writes (including tohost and out-of-range writes)
// -----------------------------------------------------------------------------
module picorv32_mem_model #(
    parameter int          MEM_WORDS     = 1024,
    parameter logic [31:0] ADDR_BASE     = 32'h0000_0000,
    parameter int          READ_LATENCY  = 1,
    parameter int          WRITE_LATENCY = 1,
    parameter logic [31:0] TOHOST_ADDR   = 32'h1000_0000,
    parameter logic [31:0] OOR_RDATA     = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic        mem_instr,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        tohost_valid,
    output logic [31:0] tohost_data,
    output logic        oor_err,
    output logic [31:0] fetch_cnt,
    output logic [31:0] load_cnt,
    output logic [31:0] store_cnt
);

    localparam int          IDX_W       = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [3:0]  RD_LAT_M1   = 4'(READ_LATENCY - 1);
    localparam logic [3:0]  WR_LAT_M1   = 4'(WRITE_LATENCY - 1);
    localparam logic [29:0] BASE_WORD   = ADDR_BASE[31:2];
    localparam logic [29:0] TOHOST_WORD = TOHOST_ADDR[31:2];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_r;
    logic [3:0]  lat_cnt_r;
    logic [29:0] addr_r;
    logic [31:0] wdata_r;
    logic [3:0]  wstrb_r;
    logic        instr_r;
    logic [31:0] mem_r [MEM_WORDS];

    logic [3:0]  lat_load_s;
    logic [29:0] idx_s;
    logic        in_range_s;
    logic        is_tohost_s;
    logic        unused_ok_s;

    // Merge the strobed byte lanes of new_word into old_word.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return res;
    endfunction

    // Byte-offset bits of the address carry no information for a word memory.
    assign unused_ok_s = &{1'b0, mem_addr[1:0]};

    // Wait-state count to load on accept, chosen by access direction.
    always_comb begin
        lat_load_s = RD_LAT_M1;
        if (mem_wstrb != 4'b0000) begin
            lat_load_s = WR_LAT_M1;
        end else begin
            lat_load_s = RD_LAT_M1;
        end
    end

    // Decode the latched word address. The subtraction wraps, so an address
    // below the base fails the >= test even though idx_s may look small.
    always_comb begin
        idx_s       = addr_r - BASE_WORD;
        in_range_s  = (addr_r >= BASE_WORD) && ({2'b00, idx_s} < 32'(MEM_WORDS));
        is_tohost_s = (addr_r == TOHOST_WORD);
    end

    // Request FSM, registered responses, memory commit and counters.
    // The memory array is intentionally left out of the reset branch.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r      <= S_IDLE;
            lat_cnt_r    <= 4'd0;
            addr_r       <= 30'd0;
            wdata_r      <= 32'd0;
            wstrb_r      <= 4'd0;
            instr_r      <= 1'b0;
            mem_ready    <= 1'b0;
            mem_rdata    <= 32'd0;
            tohost_valid <= 1'b0;
            tohost_data  <= 32'd0;
            oor_err      <= 1'b0;
            fetch_cnt    <= 32'd0;
            load_cnt     <= 32'd0;
            store_cnt    <= 32'd0;
        end else begin
            mem_ready    <= 1'b0;
            tohost_valid <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (mem_valid) begin
                        addr_r    <= mem_addr[31:2];
                        wdata_r   <= mem_wdata;
                        wstrb_r   <= mem_wstrb;
                        instr_r   <= mem_instr;
                        lat_cnt_r <= lat_load_s;
                        if (lat_load_s == 4'd0) begin
                            state_r <= S_RESP;
                        end else begin
                            state_r <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // Dropping mem_valid mid-wait abandons the access silently.
                    if (!mem_valid) begin
                        state_r <= S_IDLE;
                    end else if (lat_cnt_r == 4'd1) begin
                        lat_cnt_r <= 4'd0;
                        state_r   <= S_RESP;
                    end else begin
                        lat_cnt_r <= lat_cnt_r - 4'd1;
                    end
                end
                S_RESP: begin
                    // mem_ready rises at this edge; no new request is sampled here.
                    mem_ready <= 1'b1;
                    state_r   <= S_IDLE;
                    if (wstrb_r == 4'b0000) begin
                        if (instr_r) begin
                            fetch_cnt <= fetch_cnt + 32'd1;
                        end else begin
                            load_cnt <= load_cnt + 32'd1;
                        end
                        if (is_tohost_s) begin
                            mem_rdata <= tohost_data;
                        end else if (in_range_s) begin
                            mem_rdata <= mem_r[idx_s[IDX_W-1:0]];
                        end else begin
                            mem_rdata <= OOR_RDATA;
                            oor_err   <= 1'b1;
                        end
                    end else begin
                        store_cnt <= store_cnt + 32'd1;
                        if (is_tohost_s) begin
                            tohost_data  <= wdata_r;
                            tohost_valid <= 1'b1;
                        end else if (in_range_s) begin
                            mem_r[idx_s[IDX_W-1:0]] <=
                                merge_lanes(mem_r[idx_s[IDX_W-1:0]], wdata_r, wstrb_r);
                        end else begin
                            oor_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_picorv32_mem_model.sv
// -----------------------------------------------------------------------------
// tb_picorv32_mem_model
// Directed bench for picorv32_mem_model. Three instances share clock and reset
// but have their own request/response signals:
//   k=0: read latency 1, write latency 1
//   k=1: read latency 3, write latency 2
//   k=2: read latency 4, write latency 4
// Every instance uses 16 words based at byte address 0x100.
// -----------------------------------------------------------------------------
module tb_picorv32_mem_model;

    logic        clk;
    logic        resetn;
    logic        valid        [3];
    logic        instr        [3];
    logic        ready        [3];
    logic [31:0] addr         [3];
    logic [31:0] wdata        [3];
    logic [3:0]  wstrb        [3];
    logic [31:0] rdata        [3];
    logic        tohost_valid [3];
    logic [31:0] tohost_data  [3];
    logic        oor_err      [3];
    logic [31:0] fetch_cnt    [3];
    logic [31:0] load_cnt     [3];
    logic [31:0] store_cnt    [3];

    int          checks;
    int          failures;
    int          lat;
    logic [31:0] rd;
    logic        th;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        picorv32_mem_model #(
            .MEM_WORDS     (16),
            .ADDR_BASE     (32'h0000_0100),
            .READ_LATENCY  ((g == 0) ? 1 : ((g == 1) ? 3 : 4)),
            .WRITE_LATENCY ((g == 0) ? 1 : ((g == 1) ? 2 : 4)),
            .TOHOST_ADDR   (32'h1000_0000),
            .OOR_RDATA     (32'hDEAD_BEEF)
        ) dut (
            .clk          (clk),
            .resetn       (resetn),
            .mem_valid    (valid[g]),
            .mem_instr    (instr[g]),
            .mem_ready    (ready[g]),
            .mem_addr     (addr[g]),
            .mem_wdata    (wdata[g]),
            .mem_wstrb    (wstrb[g]),
            .mem_rdata    (rdata[g]),
            .tohost_valid (tohost_valid[g]),
            .tohost_data  (tohost_data[g]),
            .oor_err      (oor_err[g]),
            .fetch_cnt    (fetch_cnt[g]),
            .load_cnt     (load_cnt[g]),
            .store_cnt    (store_cnt[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One access on instance k; lat = edges from the accepting edge to the
    // edge that raised mem_ready (40 means it never came).
    task automatic access(input int k, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic ins,
                          output int l, output logic [31:0] r, output logic t);
        addr[k]  = a;
        wdata[k] = d;
        wstrb[k] = s;
        instr[k] = ins;
        valid[k] = 1'b1;
        @(posedge clk); #1;
        l = 0;
        while (!ready[k] && l < 40) begin
            @(posedge clk); #1;
            l++;
        end
        r = rdata[k];
        t = tohost_valid[k];
        valid[k] = 1'b0;
        wstrb[k] = 4'b0000;
        instr[k] = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        for (int k = 0; k < 3; k++) begin
            valid[k] = 1'b0; instr[k] = 1'b0; addr[k] = 32'd0;
            wdata[k] = 32'd0; wstrb[k] = 4'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({ready[k], tohost_valid[k], oor_err[k]} !== 3'b000) begin
                failures++;
                $display("FAIL reset_flags k=%0d got=%b exp=000", k, {ready[k], tohost_valid[k], oor_err[k]});
            end
            checks++;
            if ({rdata[k], tohost_data[k]} !== 64'd0) begin
                failures++;
                $display("FAIL reset_data k=%0d got=%h exp=0", k, {rdata[k], tohost_data[k]});
            end
            checks++;
            if ({fetch_cnt[k], load_cnt[k], store_cnt[k]} !== 96'd0) begin
                failures++;
                $display("FAIL reset_counts k=%0d got=%h exp=0", k, {fetch_cnt[k], load_cnt[k], store_cnt[k]});
            end
        end
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fetch();
        access(0, 32'h0000_0100, 32'h0000_0013, 4'b1111, 1'b0, lat, rd, th);
        checks++;
        if (lat !== 1) begin failures++; $display("FAIL fetch_wr_lat got=%0d exp=1", lat); end
        access(0, 32'h0000_0100, 32'd0, 4'b0000, 1'b1, lat, rd, th);
        checks++;
        if (lat !== 1) begin failures++; $display("FAIL fetch_lat got=%0d exp=1", lat); end
        checks++;
        if (rd !== 32'h0000_0013) begin failures++; $display("FAIL fetch_data got=%h exp=00000013", rd); end
        checks++;
        if ({fetch_cnt[0], load_cnt[0], store_cnt[0]} !== {32'd1, 32'd0, 32'd1}) begin
            failures++;
            $display("FAIL fetch_counts got=%0d/%0d/%0d exp=1/0/1", fetch_cnt[0], load_cnt[0], store_cnt[0]);
        end
    endtask

    task automatic test_latency();
        access(1, 32'h0000_0108, 32'h1234_5678, 4'b1111, 1'b0, lat, rd, th);
        checks++;
        if (lat !== 2) begin failures++; $display("FAIL lat_write got=%0d exp=2", lat); end
        access(1, 32'h0000_0108, 32'd0, 4'b0000, 1'b0, lat, rd, th);
        checks++;
        if (lat !== 3) begin failures++; $display("FAIL lat_read got=%0d exp=3", lat); end
        checks++;
        if (rd !== 32'h1234_5678) begin failures++; $display("FAIL lat_data got=%h exp=12345678", rd); end
        checks++;
        if ({load_cnt[1], store_cnt[1]} !== {32'd1, 32'd1}) begin
            failures++;
            $display("FAIL lat_counts got=%0d/%0d exp=1/1", load_cnt[1], store_cnt[1]);
        end
    endtask

    task automatic test_byte_strobe();
        access(0, 32'h0000_0110, 32'h1122_3344, 4'b1111, 1'b0, lat, rd, th);
        access(0, 32'h0000_0110, 32'hAABB_CCDD, 4'b0101, 1'b0, lat, rd, th);
        access(0, 32'h0000_0110, 32'd0, 4'b0000, 1'b0, lat, rd, th);
        checks++;
        if (rd !== 32'h11BB_33DD) begin failures++; $display("FAIL strobe_data got=%h exp=11bb33dd", rd); end
        checks++;
        if (store_cnt[0] !== 32'd3) begin failures++; $display("FAIL strobe_store_cnt got=%0d exp=3", store_cnt[0]); end
    endtask

    task automatic test_out_of_range();
        checks++;
        if (oor_err[0] !== 1'b0) begin failures++; $display("FAIL oor_pre got=%b exp=0", oor_err[0]); end
        access(0, 32'h0000_0140, 32'd0, 4'b0000, 1'b0, lat, rd, th);
        checks++;
        if (rd !== 32'hDEAD_BEEF || lat !== 1) begin
            failures++;
            $display("FAIL oor_top got=%h lat=%0d exp=deadbeef lat=1", rd, lat);
        end
        checks++;
        if (oor_err[0] !== 1'b1) begin failures++; $display("FAIL oor_flag got=%b exp=1", oor_err[0]); end
        access(0, 32'h0000_00FC, 32'd0, 4'b0000, 1'b0, lat, rd, th);
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL oor_below got=%h exp=deadbeef", rd); end
        // Out-of-range write must not alias onto word 0.
        access(0, 32'h0000_0140, 32'hFFFF_FFFF, 4'b1111, 1'b0, lat, rd, th);
        access(0, 32'h0000_0100, 32'd0, 4'b0000, 1'b1, lat, rd, th);
        checks++;
        if (rd !== 32'h0000_0013) begin failures++; $display("FAIL oor_wr_dropped got=%h exp=00000013", rd); end
        checks++;
        if (oor_err[0] !== 1'b1) begin failures++; $display("FAIL oor_sticky got=%b exp=1", oor_err[0]); end
        checks++;
        if ({fetch_cnt[0], load_cnt[0], store_cnt[0]} !== {32'd2, 32'd3, 32'd4}) begin
            failures++;
            $display("FAIL oor_counts got=%0d/%0d/%0d exp=2/3/4", fetch_cnt[0], load_cnt[0], store_cnt[0]);
        end
    endtask

    task automatic test_tohost();
        access(1, 32'h0000_0100, 32'h0BAD_F00D, 4'b1111, 1'b0, lat, rd, th);
        access(1, 32'h1000_0000, 32'h0000_0001, 4'b1111, 1'b0, lat, rd, th);
        checks++;
        if (th !== 1'b1) begin failures++; $display("FAIL tohost_pulse got=%b exp=1", th); end
        checks++;
        if (tohost_data[1] !== 32'h0000_0001) begin failures++; $display("FAIL tohost_data got=%h exp=00000001", tohost_data[1]); end
        @(posedge clk); #1;
        checks++;
        if (tohost_valid[1] !== 1'b0) begin failures++; $display("FAIL tohost_one_cycle got=%b exp=0", tohost_valid[1]); end
        access(1, 32'h1000_0000, 32'hCAFE_0001, 4'b0001, 1'b0, lat, rd, th);
        checks++;
        if (tohost_data[1] !== 32'hCAFE_0001) begin failures++; $display("FAIL tohost_full_word got=%h exp=cafe0001", tohost_data[1]); end
        access(1, 32'h1000_0000, 32'd0, 4'b0000, 1'b0, lat, rd, th);
        checks++;
        if (rd !== 32'hCAFE_0001) begin failures++; $display("FAIL tohost_read got=%h exp=cafe0001", rd); end
        access(1, 32'h0000_0100, 32'd0, 4'b0000, 1'b0, lat, rd, th);
        checks++;
        if (rd !== 32'h0BAD_F00D) begin failures++; $display("FAIL tohost_no_mem got=%h exp=0badf00d", rd); end
        checks++;
        if (oor_err[1] !== 1'b0 || store_cnt[1] !== 32'd4) begin
            failures++;
            $display("FAIL tohost_oor_store got=%b/%0d exp=0/4", oor_err[1], store_cnt[1]);
        end
    endtask

    task automatic test_back_to_back();
        time t1;
        time t2;
        logic [31:0] rd1;
        access(0, 32'h0000_0110, 32'd0, 4'b0000, 1'b0, lat, rd1, th);
        t1 = $time;
        access(0, 32'h0000_0100, 32'd0, 4'b0000, 1'b0, lat, rd, th);
        t2 = $time;
        checks++;
        if ((t2 - t1) !== 64'd20) begin failures++; $display("FAIL b2b_spacing got=%0t exp=20", t2 - t1); end
        checks++;
        if ({rd1, rd} !== {32'h11BB_33DD, 32'h0000_0013}) begin
            failures++;
            $display("FAIL b2b_data got=%h/%h exp=11bb33dd/00000013", rd1, rd);
        end
        @(posedge clk); #1;
        checks++;
        if (ready[0] !== 1'b0) begin failures++; $display("FAIL b2b_ready_width got=%b exp=0", ready[0]); end
        checks++;
        if (load_cnt[0] !== 32'd5) begin failures++; $display("FAIL b2b_load_cnt got=%0d exp=5", load_cnt[0]); end
    endtask

    task automatic test_abort_reset();
        logic saw;
        access(2, 32'h0000_010C, 32'h0000_0055, 4'b1111, 1'b0, lat, rd, th);
        checks++;
        if (lat !== 4) begin failures++; $display("FAIL abort_wr_lat got=%0d exp=4", lat); end
        // Abandon a write while it is waiting.
        addr[2] = 32'h0000_010C; wdata[2] = 32'h0000_00FF; wstrb[2] = 4'b1111; valid[2] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        valid[2] = 1'b0;
        wstrb[2] = 4'b0000;
        saw = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ready[2]) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0) begin failures++; $display("FAIL abort_no_ready got=%b exp=0", saw); end
        checks++;
        if (store_cnt[2] !== 32'd1) begin failures++; $display("FAIL abort_store_cnt got=%0d exp=1", store_cnt[2]); end
        access(2, 32'h0000_010C, 32'd0, 4'b0000, 1'b0, lat, rd, th);
        checks++;
        if (rd !== 32'h0000_0055 || lat !== 4) begin
            failures++;
            $display("FAIL abort_no_write got=%h lat=%0d exp=00000055 lat=4", rd, lat);
        end
        // Reset asserted mid-wait, away from any clock edge.
        addr[2] = 32'h0000_010C; valid[2] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #2;
        resetn = 1'b0;
        #1;
        checks++;
        if ({ready[2], rdata[2], load_cnt[2], store_cnt[2], oor_err[0]} !== 98'd0) begin
            failures++;
            $display("FAIL async_reset got=%b/%h/%0d/%0d/%b exp=0", ready[2], rdata[2], load_cnt[2], store_cnt[2], oor_err[0]);
        end
        valid[2] = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ready[2] !== 1'b0) begin failures++; $display("FAIL reset_discard got=%b exp=0", ready[2]); end
        access(2, 32'h0000_010C, 32'd0, 4'b0000, 1'b0, lat, rd, th);
        checks++;
        if (rd !== 32'h0000_0055 || load_cnt[2] !== 32'd1) begin
            failures++;
            $display("FAIL mem_kept got=%h/%0d exp=00000055/1", rd, load_cnt[2]);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_fetch();
        test_latency();
        test_byte_strobe();
        test_out_of_range();
        test_tohost();
        test_back_to_back();
        test_abort_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
